// File: rtl/mux16_rr_sched_pkg.sv
// Shared constants and types for the mux16 round-robin scheduler.
package mux16_rr_sched_pkg;

   localparam int unsigned N_REQ = 16;
   localparam int unsigned SEL_W = 4;
   localparam int unsigned IDX_W = 8;

   typedef enum logic {IDLE, XFER} sched_state_t;

   typedef logic [N_REQ-1:0] req_vec_t;

endpackage

// File: rtl/mux16_rr_sched_rr_pick16.sv
// Combinational round-robin pick: rotate requests past the last grant, priority-encode,
// then un-rotate back to an absolute requester index.
module rr_pick16
   import mux16_rr_sched_pkg::*;
(
   input  req_vec_t         req,
   input  logic [SEL_W-1:0] last,
   output logic             any,
   output logic [SEL_W-1:0] pick
);

   logic [SEL_W-1:0] w_start;
   req_vec_t         w_rot;
   logic [SEL_W-1:0] w_off;

   assign w_start = last + 4'd1;

   // w_rot[0] is the requester immediately after the last grant.
   always_comb begin
      w_rot = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_rot[i] = req[w_start + SEL_W'(i)];
      end
   end

   always_comb begin
      w_off = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) w_off = SEL_W'(i);
      end
   end

   assign any  = |req;
   assign pick = w_start + w_off;

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler granting the 16:1 mux datapath in fixed-length bursts.
// Optional stall timeout enabled by defining MUX16_RR_SCHED_STALL_TIMEOUT_EN.
module mux16_rr_sched
   import mux16_rr_sched_pkg::*;
#(
   parameter int unsigned BURST_LEN = 8,
   parameter int unsigned TIMEOUT   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  req_vec_t         req,
   input  logic             out_ready,
   output logic [SEL_W-1:0] sel,
   output req_vec_t         gnt,
   output logic             out_valid,
   output logic [IDX_W-1:0] bit_idx,
   output logic             burst_done,
   output logic             burst_abort
);

   if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_burst
      $error("BURST_LEN out of range");
   end
   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("TIMEOUT out of range");
   end

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(BURST_LEN - 1);

   sched_state_t     r_state, w_state_d;
   logic [SEL_W-1:0] r_last, w_last_d;
   logic [SEL_W-1:0] r_sel, w_sel_d;
   req_vec_t         r_gnt, w_gnt_d;
   logic             r_valid, w_valid_d;
   logic [IDX_W-1:0] r_idx, w_idx_d;
   logic             r_done, w_done_d;
   logic             r_abort, w_abort_d;

   logic             w_any;
   logic [SEL_W-1:0] w_pick;
   logic             w_timeout;

   rr_pick16 u_pick (
      .req  (req),
      .last (r_last),
      .any  (w_any),
      .pick (w_pick)
   );

`ifdef MUX16_RR_SCHED_STALL_TIMEOUT_EN
   logic [15:0] r_stall, w_stall_d;

   // Counter self-clears on any transfer, abort or idle cycle via the default.
   always_comb begin
      w_stall_d = '0;
      w_timeout = 1'b0;
      if (r_state == XFER && !out_ready && req[r_sel]) begin
         if (({1'b0, r_stall} + 17'd1) >= 17'(TIMEOUT)) w_timeout = 1'b1;
         else                                           w_stall_d = r_stall + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_stall <= '0;
      else        r_stall <= w_stall_d;
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_state_d = r_state;
      w_last_d  = r_last;
      w_sel_d   = r_sel;
      w_gnt_d   = r_gnt;
      w_valid_d = r_valid;
      w_idx_d   = r_idx;
      w_done_d  = 1'b0;
      w_abort_d = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_d = XFER;
               w_sel_d   = w_pick;
               w_gnt_d   = req_vec_t'(1) << w_pick;
               w_idx_d   = '0;
               w_valid_d = 1'b1;
            end
         end
         XFER: begin
            // Abort wins over a simultaneous transfer, even on the final bit.
            if (!req[r_sel] || w_timeout) begin
               w_abort_d = 1'b1;
               w_last_d  = r_sel;
               w_state_d = IDLE;
               w_gnt_d   = '0;
               w_valid_d = 1'b0;
               w_idx_d   = '0;
            end else if (out_ready) begin
               if (r_idx == LastIdx) begin
                  w_done_d  = 1'b1;
                  w_last_d  = r_sel;
                  w_state_d = IDLE;
                  w_gnt_d   = '0;
                  w_valid_d = 1'b0;
                  w_idx_d   = '0;
               end else begin
                  w_idx_d = r_idx + 8'd1;
               end
            end
         end
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_last  <= 4'd15;
         r_sel   <= '0;
         r_gnt   <= '0;
         r_valid <= 1'b0;
         r_idx   <= '0;
         r_done  <= 1'b0;
         r_abort <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_last  <= w_last_d;
         r_sel   <= w_sel_d;
         r_gnt   <= w_gnt_d;
         r_valid <= w_valid_d;
         r_idx   <= w_idx_d;
         r_done  <= w_done_d;
         r_abort <= w_abort_d;
      end
   end

   assign sel         = r_sel;
   assign gnt         = r_gnt;
   assign out_valid   = r_valid;
   assign bit_idx     = r_idx;
   assign burst_done  = r_done;
   assign burst_abort = r_abort;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Directed self-checking bench for mux16_rr_sched with BURST_LEN=8.
module tb_mux16_rr_sched;
   import mux16_rr_sched_pkg::*;

   logic             clk;
   logic             rst_n;
   req_vec_t         req;
   logic             out_ready;
   logic [SEL_W-1:0] sel;
   req_vec_t         gnt;
   logic             out_valid;
   logic [IDX_W-1:0] bit_idx;
   logic             burst_done;
   logic             burst_abort;

   int n_assert;
   int n_fail;

   mux16_rr_sched #(
      .BURST_LEN (8),
      .TIMEOUT   (32)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .out_ready   (out_ready),
      .sel         (sel),
      .gnt         (gnt),
      .out_valid   (out_valid),
      .bit_idx     (bit_idx),
      .burst_done  (burst_done),
      .burst_abort (burst_abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req       = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic check_grant(input string tag, input int unsigned r);
      check({tag, ".sel"}, 32'(sel), 32'(r));
      check({tag, ".gnt"}, 32'(gnt), 32'(32'd1 << r));
      check({tag, ".valid"}, 32'(out_valid), 32'd1);
      check({tag, ".idx"}, 32'(bit_idx), 32'd0);
   endtask

   task automatic check_idle(input string tag, input logic done, input logic abort);
      check({tag, ".valid"}, 32'(out_valid), 32'd0);
      check({tag, ".gnt"}, 32'(gnt), 32'd0);
      check({tag, ".done"}, 32'(burst_done), 32'(done));
      check({tag, ".abort"}, 32'(burst_abort), 32'(abort));
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;

      // Reset state
      do_reset();
      check("rst.sel", 32'(sel), 32'd0);
      check("rst.idx", 32'(bit_idx), 32'd0);
      check_idle("rst", 1'b0, 1'b0);

      // Single requester: full burst, bubble, re-grant
      req       = 16'h0001;
      out_ready = 1'b1;
      step();
      check_grant("s1.grant", 0);
      for (int k = 1; k < 8; k++) begin
         step();
         check("s1.idx", 32'(bit_idx), 32'(k));
         check("s1.valid", 32'(out_valid), 32'd1);
      end
      step();
      check_idle("s1.end", 1'b1, 1'b0);
      step();
      check_grant("s1.regrant", 0);
      check("s1.done_pulse", 32'(burst_done), 32'd0);

      // All requesting: strict rotation 0..15,0
      do_reset();
      req       = 16'hFFFF;
      out_ready = 1'b1;
      for (int g = 0; g < 17; g++) begin
         step();
         check_grant("s2.grant", g % 16);
         repeat (7) step();
         check("s2.last_idx", 32'(bit_idx), 32'd7);
         check("s2.last_valid", 32'(out_valid), 32'd1);
         step();
         check_idle("s2.bubble", 1'b1, 1'b0);
      end

      // Stall at bit 3 on requester 5
      do_reset();
      req       = 16'h0020;
      out_ready = 1'b1;
      step();
      check_grant("s3.grant", 5);
      repeat (3) step();
      check("s3.idx3", 32'(bit_idx), 32'd3);
      out_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         check("s3.stall_sel", 32'(sel), 32'd5);
         check("s3.stall_idx", 32'(bit_idx), 32'd3);
         check("s3.stall_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      for (int k = 4; k < 8; k++) begin
         step();
         check("s3.resume_idx", 32'(bit_idx), 32'(k));
      end
      step();
      check_idle("s3.end", 1'b1, 1'b0);

      // Abort on requester 9, wrap to requester 2, then abort on final bit
      do_reset();
      req       = 16'h0200;
      out_ready = 1'b1;
      step();
      check_grant("s4.grant", 9);
      repeat (4) step();
      check("s4.idx4", 32'(bit_idx), 32'd4);
      req = 16'h0004;
      step();
      check_idle("s4.abort", 1'b0, 1'b1);
      step();
      check_grant("s4.wrap", 2);
      check("s4.abort_pulse", 32'(burst_abort), 32'd0);
      repeat (7) step();
      check("s4.idx7", 32'(bit_idx), 32'd7);
      req = 16'h0000;
      step();
      check_idle("s4.final_abort", 1'b0, 1'b1);
      step();
      check_idle("s4.quiet", 1'b0, 1'b0);

      // Asynchronous reset mid-burst
      do_reset();
      req       = 16'h0001;
      out_ready = 1'b1;
      step();
      repeat (5) step();
      check("s5.idx5", 32'(bit_idx), 32'd5);
      #2;
      rst_n = 1'b0;
      #1;
      check("s5.async_valid", 32'(out_valid), 32'd0);
      check("s5.async_gnt", 32'(gnt), 32'd0);
      check("s5.async_idx", 32'(bit_idx), 32'd0);
      check("s5.async_pulses", 32'({burst_done, burst_abort}), 32'd0);
      req = 16'h8001;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check_grant("s5.grant", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
